// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional parity, NB_STOP stop bits,
// each bit lasting SB_TICK oversample ticks. The serial line comes straight from a flop.
`timescale 1ns/1ps
module uart_transmitter #(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned SB_TICK     = 16,
  parameter logic [1:0]  F_TX_PARITY = 2'b00,
  parameter int unsigned NB_STOP     = 1
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_busy,
  output logic               o_tx_done
);

  localparam int unsigned STOP_TICKS = NB_STOP * SB_TICK;
  localparam int unsigned TICK_W     = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
  localparam int unsigned BIT_W      = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(NB_DATA - 1);
  localparam logic PAR_EN  = (F_TX_PARITY == 2'b01) || (F_TX_PARITY == 2'b10);
  localparam logic PAR_ODD = (F_TX_PARITY == 2'b10);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic [NB_DATA-1:0] shifted;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  assign shifted = shreg_q >> 1;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // tx_d always carries the level of the bit being entered, so o_tx is a plain flop output.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (i_tx_start) begin
          shreg_d = i_data;
          par_d   = (^i_data) ^ PAR_ODD;
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end

      StStart: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            tx_d    = shreg_q[0];
            state_d = StData;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      StData: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d = '0;
            if (bit_q == DATA_LAST) begin
              if (PAR_EN) begin
                tx_d    = par_q;
                state_d = StParity;
              end else begin
                tx_d    = 1'b1;
                state_d = StStop;
              end
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = shifted;
              tx_d    = shifted[0];
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      StParity: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      StStop: begin
        tx_d = 1'b1;
        if (i_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  assign o_tx      = tx_q;
  assign o_tx_busy = (state_q != StIdle);
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four configurations driven in parallel, frames checked bit by bit
// at mid-bit against a scoreboard of expected frames, plus abort and back-to-back sequences.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int NDUT = 4;
  localparam int PAR_MODE [NDUT] = '{0, 1, 2, 0};
  localparam int N_STOP   [NDUT] = '{1, 1, 1, 2};
  localparam int FRAME_TICKS [NDUT] = '{160, 176, 176, 176};

  logic       clk = 1'b0;
  logic       rst, tick, start;
  logic [7:0] data;
  logic       tx_w [NDUT];
  logic       busy_w [NDUT];
  logic       done_w [NDUT];

  always #5 clk = ~clk;

  uart_transmitter #(.NB_DATA(8), .SB_TICK(16), .F_TX_PARITY(2'b00), .NB_STOP(1)) u_d0 (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start), .i_data(data),
    .o_tx(tx_w[0]), .o_tx_busy(busy_w[0]), .o_tx_done(done_w[0]));
  uart_transmitter #(.NB_DATA(8), .SB_TICK(16), .F_TX_PARITY(2'b01), .NB_STOP(1)) u_d1 (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start), .i_data(data),
    .o_tx(tx_w[1]), .o_tx_busy(busy_w[1]), .o_tx_done(done_w[1]));
  uart_transmitter #(.NB_DATA(8), .SB_TICK(16), .F_TX_PARITY(2'b10), .NB_STOP(1)) u_d2 (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start), .i_data(data),
    .o_tx(tx_w[2]), .o_tx_busy(busy_w[2]), .o_tx_done(done_w[2]));
  uart_transmitter #(.NB_DATA(8), .SB_TICK(16), .F_TX_PARITY(2'b00), .NB_STOP(2)) u_d3 (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start), .i_data(data),
    .o_tx(tx_w[3]), .o_tx_busy(busy_w[3]), .o_tx_done(done_w[3]));

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          ticks;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic       even_bit;
  } vec_t;

  frame_t exp_q [NDUT][$];
  frame_t cur [NDUT];
  int     cnt [NDUT];
  logic   in_frame [NDUT];
  logic   busy_prev [NDUT];
  int     done_cnt [NDUT];
  int     exp_done [NDUT];
  int     total = 0;
  int     bad = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic frame_t build(input logic [7:0] d, input logic even_bit, input int pm,
                                   input int ns, input int ticks);
    frame_t f;
    int n;
    f.bits = '0;
    n = 1;  // bit 0 is the start bit, already 0
    for (int i = 0; i < 8; i++) begin
      f.bits[n] = d[i];
      n++;
    end
    if (pm == 1) begin
      f.bits[n] = even_bit;
      n++;
    end else if (pm == 2) begin
      f.bits[n] = ~even_bit;
      n++;
    end
    for (int s = 0; s < ns; s++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = n;
    f.ticks = ticks;
    return f;
  endfunction

  task automatic expect_frame(input logic [7:0] d, input logic even_bit, input logic [3:0] mask);
    for (int k = 0; k < NDUT; k++) begin
      if (mask[k]) begin
        exp_q[k].push_back(build(d, even_bit, PAR_MODE[k], N_STOP[k], FRAME_TICKS[k]));
        exp_done[k]++;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic even_bit);
    @(negedge clk);
    data  = d;
    start = 1'b1;
    expect_frame(d, even_bit, 4'hF);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int  n;
    logic idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
      idle = 1'b1;
      for (int k = 0; k < NDUT; k++)
        if (busy_w[k] || in_frame[k] || exp_q[k].size() != 0) idle = 1'b0;
    end
    if (!idle) chk("wait_idle_timeout", 0, 1, 0);
  endtask

  // Tick strobe: one clk wide every 4 clks, free-running (also during idle and reset).
  initial begin
    int tdiv;
    tdiv = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv++;
      tick = (tdiv % 4 == 0);
    end
  end

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    for (int k = 0; k < NDUT; k++) begin
      in_frame[k]  = 1'b0;
      busy_prev[k] = 1'b0;
      cnt[k]       = 0;
      done_cnt[k]  = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < NDUT; k++) begin
        if (rst) begin
          in_frame[k]  = 1'b0;
          busy_prev[k] = 1'b0;
        end else begin
          if (in_frame[k] && tick) begin
            cnt[k]++;
            if (cnt[k] % 16 == 8 && cnt[k] / 16 < cur[k].nbits)
              chk("frame_bit", k, tx_w[k], cur[k].bits[cnt[k] / 16]);
          end
          if (in_frame[k] && !busy_w[k] && !done_w[k]) chk("busy_drop", k, 1, 0);
          if (done_w[k]) begin
            if (!in_frame[k]) begin
              chk("spurious_done", k, 1, 0);
            end else begin
              chk("frame_ticks", k, cnt[k], cur[k].ticks);
              chk("busy_at_done", k, busy_w[k], 0);
            end
            done_cnt[k]++;
            in_frame[k] = 1'b0;
          end
          if (!busy_prev[k] && busy_w[k]) begin
            chk("start_latency", k, tx_w[k], 0);
            if (exp_q[k].size() == 0) begin
              chk("unexpected_frame", k, 1, 0);
            end else begin
              cur[k]      = exp_q[k].pop_front();
              in_frame[k] = 1'b1;
              cnt[k]      = 0;
            end
          end
          busy_prev[k] = busy_w[k];
        end
      end
    end
  end

  initial begin
    vec_t vecs [8];
    int   n;
    logic idle_ok [NDUT];

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'hA0, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h01, 1'b1};
    vecs[6] = '{8'h80, 1'b1};
    vecs[7] = '{8'hC5, 1'b0};
    for (int k = 0; k < NDUT; k++) exp_done[k] = 0;

    rst   = 1'b0;
    start = 1'b0;
    data  = 8'h00;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_tx", k, tx_w[k], 1);
      chk("reset_busy", k, busy_w[k], 0);
      chk("reset_done", k, done_w[k], 0);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);  // idle ticks must not disturb the first frame

    for (int v = 0; v < 8; v++) begin
      send(vecs[v].data, vecs[v].even_bit);
      wait_idle(3000);
    end

    // Start pulse with new data in mid-frame must be dropped.
    send(8'h00, 1'b0);
    repeat (120) @(negedge clk);
    data  = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(3000);
    repeat (100) @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk("no_queued_frame", k, busy_w[k], 0);

    // Start held: dut0 (shortest frame) restarts one clk after done; others finish once.
    @(negedge clk);
    data  = 8'h3C;
    start = 1'b1;
    expect_frame(8'h3C, 1'b0, 4'hF);
    expect_frame(8'h3C, 1'b0, 4'h1);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!done_w[0] && n < 2000);
    chk("b2b_done_seen", 0, done_w[0], 1);
    chk("b2b_gap_tx", 0, tx_w[0], 1);
    @(posedge clk);
    #2;
    chk("b2b_restart_busy", 0, busy_w[0], 1);
    chk("b2b_restart_tx", 0, tx_w[0], 0);
    @(negedge clk);
    start = 1'b0;
    wait_idle(3000);

    // Reset during data bit 3 aborts the frame asynchronously.
    send(8'h55, 1'b0);
    n = 0;
    while (cnt[0] != 70 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_bit3", 0, cnt[0], 70);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("abort_tx", k, tx_w[k], 1);
      chk("abort_busy", k, busy_w[k], 0);
      exp_done[k]--;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) idle_ok[k] = 1'b1;
    repeat (200) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++)
        if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) idle_ok[k] = 1'b0;
    end
    for (int k = 0; k < NDUT; k++) chk("idle_after_abort", k, idle_ok[k], 1);

    for (int k = 0; k < NDUT; k++) begin
      chk("done_count", k, done_cnt[k], exp_done[k]);
      chk("scoreboard_empty", k, exp_q[k].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
